// File: rtl/id_stage.sv
// Instruction decode stage: register file, decoder, hazard detection, branch
// resolution and the ID/EX pipeline register.
module id_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned RA = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     id_inst,
   input  logic [XLEN-1:0] id_pc_4,
   input  logic            id_valid,
   input  logic            wb_we,
   input  logic [RA-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_stall,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            ex_valid,
   output logic            ex_wreg,
   output logic            ex_m2reg,
   output logic            ex_wmem,
   output logic            ex_aluimm,
   output logic [3:0]      ex_aluc,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [XLEN-1:0] ex_imm,
   output logic [RA-1:0]   ex_rs,
   output logic [RA-1:0]   ex_rt,
   output logic [RA-1:0]   ex_dest
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [RA-1:0]   rs;
   logic [RA-1:0]   rt;
   logic [RA-1:0]   rd;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] imm_zext;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic [XLEN-1:0] regs [1:NREG-1];

   logic            d_ok;
   logic            d_wreg;
   logic            d_m2reg;
   logic            d_wmem;
   logic            d_aluimm;
   logic            d_zext;
   logic [3:0]      d_aluc;
   logic [RA-1:0]   d_dest;
   logic            use_rs;
   logic            use_rt;
   logic            is_beq;
   logic            is_bne;
   logic            is_j;
   logic            load_use;
   logic            br_hazard;
   logic            issue;

   assign op       = id_inst[31:26];
   assign funct    = id_inst[5:0];
   assign rs       = RA'(id_inst[25:21]);
   assign rt       = RA'(id_inst[20:16]);
   assign rd       = RA'(id_inst[15:11]);
   assign imm_sext = {{(XLEN-16){id_inst[15]}}, id_inst[15:0]};
   assign imm_zext = {{(XLEN-16){1'b0}}, id_inst[15:0]};

   // Register file; r0 is not stored and always reads zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < int'(NREG); i++) regs[i] <= '0;
      end else if (wb_we && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Write-through lets the WB result reach ID in the same cycle
   assign rs_val = (rs == '0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : regs[rs];
   assign rt_val = (rt == '0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : regs[rt];

   // Decoder: unsupported encodings leave d_ok low and become bubbles
   always_comb begin
      d_ok     = 1'b0;
      d_wreg   = 1'b0;
      d_m2reg  = 1'b0;
      d_wmem   = 1'b0;
      d_aluimm = 1'b0;
      d_zext   = 1'b0;
      d_aluc   = ALU_ADD;
      d_dest   = '0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      is_beq   = 1'b0;
      is_bne   = 1'b0;
      is_j     = 1'b0;
      case (op)
         OP_RTYPE: begin
            d_ok   = 1'b1;
            d_wreg = 1'b1;
            d_dest = rd;
            use_rs = 1'b1;
            use_rt = 1'b1;
            case (funct)
               FN_ADD:  d_aluc = ALU_ADD;
               FN_SUB:  d_aluc = ALU_SUB;
               FN_AND:  d_aluc = ALU_AND;
               FN_OR:   d_aluc = ALU_OR;
               FN_SLT:  d_aluc = ALU_SLT;
               default: begin
                  d_ok   = 1'b0;
                  d_wreg = 1'b0;
                  d_dest = '0;
                  use_rs = 1'b0;
                  use_rt = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
            d_ok     = 1'b1;
            d_wreg   = 1'b1;
            d_aluimm = 1'b1;
            d_dest   = rt;
            use_rs   = 1'b1;
            d_m2reg  = (op == OP_LW);
            d_zext   = (op == OP_ANDI) || (op == OP_ORI);
            d_aluc   = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
         end
         OP_SW: begin
            d_ok     = 1'b1;
            d_wmem   = 1'b1;
            d_aluimm = 1'b1;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            d_ok   = 1'b1;
            d_aluc = ALU_SUB;
            use_rs = 1'b1;
            use_rt = 1'b1;
            is_beq = (op == OP_BEQ);
            is_bne = (op == OP_BNE);
         end
         OP_J: begin
            d_ok = 1'b1;
            is_j = 1'b1;
         end
         default: ;
      endcase
   end

   // Hazards are judged against the instruction currently held in ID/EX
   assign load_use  = ex_valid && ex_m2reg && (ex_dest != '0) &&
                      ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
   assign br_hazard = (is_beq || is_bne) && ex_valid && ex_wreg && (ex_dest != '0) &&
                      (ex_dest == rs || ex_dest == rt);
   assign id_stall  = id_valid && (load_use || br_hazard);
   assign issue     = id_valid && d_ok && !id_stall;

   assign branch_taken  = id_valid && !id_stall &&
                          ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) || is_j);
   assign branch_target = is_j ? {id_pc_4[XLEN-1:28], id_inst[25:0], 2'b00}
                               : id_pc_4 + {imm_sext[XLEN-3:0], 2'b00};

   // ID/EX register: loads the decoded instruction or a zeroed bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst || !issue) begin
         ex_valid  <= 1'b0;
         ex_wreg   <= 1'b0;
         ex_m2reg  <= 1'b0;
         ex_wmem   <= 1'b0;
         ex_aluimm <= 1'b0;
         ex_aluc   <= '0;
         ex_a      <= '0;
         ex_b      <= '0;
         ex_imm    <= '0;
         ex_rs     <= '0;
         ex_rt     <= '0;
         ex_dest   <= '0;
      end else begin
         ex_valid  <= 1'b1;
         ex_wreg   <= d_wreg && (d_dest != '0);
         ex_m2reg  <= d_m2reg;
         ex_wmem   <= d_wmem;
         ex_aluimm <= d_aluimm;
         ex_aluc   <= d_aluc;
         ex_a      <= rs_val;
         ex_b      <= rt_val;
         ex_imm    <= d_zext ? imm_zext : imm_sext;
         ex_rs     <= rs;
         ex_rt     <= rt;
         ex_dest   <= d_dest;
      end
   end

endmodule
